// File: rtl/fsk_mod.sv
// fsk_mod -- binary continuous-phase FSK modulator.
//
// One data bit is accepted per baud period over a valid/ready handshake and
// sent as a mark (bit 1) or space (bit 0) tone. The tone comes from a
// phase-accumulator DDS that addresses a 1024-entry sine table. The output is
// a 10-bit offset-binary DAC word, so the 10-bit receive path can sample it
// directly.
//
// Ports:
//   clk         system clock (single domain)
//   rst         synchronous active-high reset
//   din         bit to transmit
//   din_valid   din is valid
//   din_ready   modulator accepts din this cycle (combinational from state)
//   dac_out     offset-binary sample, mid-scale 512
//   busy        high while RUN or DRAIN
//   bit_strobe  one-cycle pulse following each accepted bit
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no tone; phase parked at 0, output at mid-scale, ready for a bit
// S_RUN   | sending cur_bit for BAUD_DIV clocks; ready only on the last one
// S_DRAIN | no next bit; finish the current tone cycle up to phase wrap

module fsk_mod #(
   parameter int                 PHASE_W  = 32,
   parameter logic [PHASE_W-1:0] F0_INC   = 134218,
   parameter logic [PHASE_W-1:0] F1_INC   = 268435,
   parameter int                 BAUD_DIV = 32000,
   parameter int                 CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [9:0] dac_out,
   output logic       busy,
   output logic       bit_strobe
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [9:0]       DAC_MID   = 10'd512;
   localparam real              PI        = 3.14159265358979323846;

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
   logic               cur_bit_q, cur_bit_d;
   logic [9:0]         dac_q, dac_d;
   logic               busy_q, busy_d;
   logic               bit_strobe_q, bit_strobe_d;

   logic               accept;
   logic [PHASE_W-1:0] phase_inc;
   logic [PHASE_W:0]   phase_sum;
   logic [9:0]         lut_val;
   logic [9:0]         sine_lut [1024];

   // Table built at elaboration from the closed-form rounding rule.
   for (genvar k = 0; k < 1024; k++) begin : g_lut
      localparam real ANG  = 2.0 * PI * real'(k) / 1024.0;
      localparam int  RAW  = $rtoi($floor(511.5 + 511.5 * $sin(ANG) + 0.5));
      localparam int  CLIP = (RAW < 0) ? 0 : ((RAW > 1023) ? 1023 : RAW);
      assign sine_lut[k] = 10'(CLIP);
   end

   assign phase_inc = cur_bit_q ? F1_INC : F0_INC;
   // Extra MSB is the carry used to detect the full-cycle wrap in DRAIN.
   assign phase_sum = {1'b0, phase_q} + {1'b0, phase_inc};
   assign lut_val   = sine_lut[phase_q[PHASE_W-1 -: 10]];

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      baud_cnt_d = baud_cnt_q;
      cur_bit_d  = cur_bit_q;
      dac_d      = dac_q;
      din_ready  = 1'b0;
      accept     = 1'b0;
      case (state_q)
         S_IDLE: begin
            din_ready = 1'b1;
            phase_d   = '0;
            dac_d     = DAC_MID;
            if (din_valid) begin
               accept     = 1'b1;
               cur_bit_d  = din;
               baud_cnt_d = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            phase_d    = phase_sum[PHASE_W-1:0];
            baud_cnt_d = baud_cnt_q + 1'b1;
            dac_d      = lut_val;
            if (baud_cnt_q == BAUD_LAST) begin
               din_ready = 1'b1;
               // Phase is not touched on a new bit: the tone stays continuous.
               if (din_valid) begin
                  accept     = 1'b1;
                  cur_bit_d  = din;
                  baud_cnt_d = '0;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            phase_d = phase_sum[PHASE_W-1:0];
            dac_d   = lut_val;
            if (phase_sum[PHASE_W]) begin
               phase_d = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      bit_strobe_d = accept;
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         baud_cnt_q   <= '0;
         cur_bit_q    <= 1'b0;
         dac_q        <= DAC_MID;
         busy_q       <= 1'b0;
         bit_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         baud_cnt_q   <= baud_cnt_d;
         cur_bit_q    <= cur_bit_d;
         dac_q        <= dac_d;
         busy_q       <= busy_d;
         bit_strobe_q <= bit_strobe_d;
      end
   end

   assign dac_out    = dac_q;
   assign busy       = busy_q;
   assign bit_strobe = bit_strobe_q;

endmodule

// File: tb/tb_fsk_mod.sv
// tb_fsk_mod -- directed bench for fsk_mod with a short baud period (8 clocks)
// and power-of-two increments, so LUT indices advance by 64 (bit 0) or
// 128 (bit 1) per clock and expected samples are hand-tabulated.

module tb_fsk_mod;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       din_ready;
   logic [9:0] dac_out;
   logic       busy;
   logic       bit_strobe;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fsk_mod #(
      .PHASE_W (32),
      .F0_INC  (32'h1000_0000),
      .F1_INC  (32'h2000_0000),
      .BAUD_DIV(8),
      .CNT_W   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dac_out   (dac_out),
      .busy      (busy),
      .bit_strobe(bit_strobe)
   );

   // Samples seen after the accepting edge, one per clock, ending in IDLE.
   // Bit 1: LUT[0,128,..,896] twice; bit 0: LUT[0,64,..,960].
   int dac_b1 [18] = '{512, 512, 873, 1023, 873, 512, 150, 0, 150,
                       512, 873, 1023, 873, 512, 150, 0, 150, 512};
   int dac_b0 [18] = '{512, 512, 707, 873, 984, 1023, 984, 873, 707,
                       512, 316, 150, 39, 0, 39, 150, 316, 512};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input logic b);
      int exp_dac;
      din       = b;
      din_valid = 1'b1;
      chk("idle_ready", 32'(din_ready), 1);
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 18; i++) begin
         exp_dac = b ? dac_b1[i] : dac_b0[i];
         chk($sformatf("dac_b%0d[%0d]", b, i), 32'(dac_out), 32'(exp_dac));
         chk($sformatf("busy_b%0d[%0d]", b, i), 32'(busy), 32'(i < 16));
         chk($sformatf("strobe_b%0d[%0d]", b, i), 32'(bit_strobe), 32'(i == 0));
         chk($sformatf("ready_b%0d[%0d]", b, i), 32'(din_ready), 32'(i == 7 || i >= 16));
         step();
      end
   endtask

   initial begin
      int n_strobe;
      int n_busy;
      int first_strobe;
      int strobe_at [3];

      // Reset held while the source already offers a bit.
      rst       = 1'b1;
      din       = 1'b1;
      din_valid = 1'b1;
      step();
      step();
      step();
      chk("rst_dac", 32'(dac_out), 512);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobe", 32'(bit_strobe), 0);
      chk("rst_ready", 32'(din_ready), 1);
      rst       = 1'b0;
      din_valid = 1'b0;
      step();

      // Lone bits: full tone cycles, then DRAIN to the phase wrap.
      run_single(1'b1);
      run_single(1'b0);

      // Back-to-back 0,1,0 with din_valid held high.
      din       = 1'b0;
      din_valid = 1'b1;
      step();
      n_strobe = 0;
      n_busy   = 0;
      for (int i = 0; i < 45; i++) begin
         if (busy) n_busy++;
         if (bit_strobe) begin
            if (n_strobe < 3) strobe_at[n_strobe] = i;
            n_strobe++;
            if (n_strobe == 1) din = 1'b1;
            if (n_strobe == 2) din = 1'b0;
            if (n_strobe == 3) din_valid = 1'b0;
         end
         if (i == 7)  chk("b2b_ready7", 32'(din_ready), 1);
         if (i == 9)  chk("b2b_dac9", 32'(dac_out), 512);
         if (i == 10) chk("b2b_dac10", 32'(dac_out), 150);
         if (i == 17) chk("b2b_dac17", 32'(dac_out), 512);
         if (i == 18) chk("b2b_dac18", 32'(dac_out), 316);
         step();
      end
      chk("b2b_nstrobe", 32'(n_strobe), 3);
      chk("b2b_strobe1", 32'(strobe_at[1]), 8);
      chk("b2b_strobe2", 32'(strobe_at[2]), 16);
      chk("b2b_busy_cycles", 32'(n_busy), 40);
      chk("b2b_end_dac", 32'(dac_out), 512);

      // din_valid raised in DRAIN must wait for IDLE.
      din       = 1'b0;
      din_valid = 1'b1;
      step();
      din_valid    = 1'b0;
      first_strobe = -1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0 && bit_strobe && first_strobe < 0) begin
            first_strobe = i;
            din_valid    = 1'b0;
         end
         if (i == 12) chk("drain_ready", 32'(din_ready), 0);
         if (i == 16) chk("drain_idle_busy", 32'(busy), 0);
         if (i == 10) begin
            din       = 1'b1;
            din_valid = 1'b1;
         end
         step();
      end
      chk("drain_accept_at", 32'(first_strobe), 17);
      chk("drain_end_busy", 32'(busy), 0);

      // Reset in the middle of a bit.
      din       = 1'b1;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();
      step();
      step();
      chk("mid_busy_pre", 32'(busy), 1);
      rst = 1'b1;
      step();
      chk("mid_rst_dac", 32'(dac_out), 512);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_strobe", 32'(bit_strobe), 0);
      chk("mid_rst_ready", 32'(din_ready), 1);
      rst = 1'b0;
      step();
      chk("post_rst_dac", 32'(dac_out), 512);
      chk("post_rst_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
